// File: rtl/mult_pkg.sv
// Shared types and constants for the shift-add multiplier.
// Holds the FSM state type, default width and count-width helper.
package mult_pkg;

  localparam int DEF_WIDTH = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Iteration counter width: ceil(log2(w)), never below one bit.
  function automatic int cnt_w(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/mult_add_stage.sv
// One combinational add/shift step of the shift-add multiplier.
// Ports: upper (P high half), m (multiplicand), lsb (P[0]),
//   last (final iteration), upper_next (new high half),
//   shift_bit (bit shifted into the low half).
// MULT_SIGNED_EN: two's-complement step (sign-extend, subtract
//   on the last iteration); otherwise unsigned.
module mult_add_stage
  import mult_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] upper,
  input  logic [WIDTH-1:0] m,
  input  logic             lsb,
  input  logic             last,
  output logic [WIDTH-1:0] upper_next,
  output logic             shift_bit
);

  logic [WIDTH:0] acc;

`ifdef MULT_SIGNED_EN
  always_comb begin
    acc = {upper[WIDTH-1], upper};
    if (lsb) begin
      // The multiplier's sign bit carries weight -2^(W-1).
      if (last) acc = acc - {m[WIDTH-1], m};
      else      acc = acc + {m[WIDTH-1], m};
    end
  end
`else
  logic unused_last;
  assign unused_last = last;

  always_comb begin
    acc = {1'b0, upper};
    if (lsb) acc = acc + {1'b0, m};
  end
`endif

  // acc[WIDTH] is the carry (or sign), so shifting the
  // WIDTH+1-bit result right by one yields the new high half.
  assign upper_next = acc[WIDTH:1];
  assign shift_bit  = acc[0];

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential shift-add multiplier, one iteration per clock.
// Ports: clk, rst (async, active-low), start, X, Y in;
//   valid (1-cycle done pulse), busy, product (2*WIDTH) out.
// MULT_SIGNED_EN selects two's-complement operands.
module shift_add_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   X,
  input  logic [WIDTH-1:0]   Y,
  output logic               valid,
  output logic               busy,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = cnt_w(WIDTH);

  state_t             state, state_d;
  logic [2*WIDTH-1:0] p, p_d;
  logic [WIDTH-1:0]   m, m_d;
  logic [CW-1:0]      count, count_d;
  logic               valid_d;

  logic               last;
  logic [WIDTH-1:0]   upper_next;
  logic               shift_bit;

  assign last = (count == CW'(WIDTH - 1));

  mult_add_stage #(
    .WIDTH(WIDTH)
  ) u_stage (
    .upper     (p[2*WIDTH-1:WIDTH]),
    .m         (m),
    .lsb       (p[0]),
    .last      (last),
    .upper_next(upper_next),
    .shift_bit (shift_bit)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      p     <= '0;
      m     <= '0;
      count <= '0;
      valid <= 1'b0;
    end else begin
      state <= state_d;
      p     <= p_d;
      m     <= m_d;
      count <= count_d;
      valid <= valid_d;
    end
  end

  always_comb begin
    state_d = state;
    p_d     = p;
    m_d     = m;
    count_d = count;
    valid_d = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          m_d     = X;
          p_d     = {{WIDTH{1'b0}}, Y};
          count_d = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        p_d     = {upper_next, shift_bit,
                   p[WIDTH-1:1]};
        count_d = count + CW'(1);
        if (last) begin
          state_d = IDLE;
          valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy    = (state == RUN);
  assign product = p;

endmodule

// File: doc/shift_add_multiplier.md
SHIFT_ADD_MULTIPLIER -- requirements
Module: shift_add_multiplier

Interface
REQ-001 Parameter: WIDTH, default 4, operand width in bits (legal range 2..16).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request to begin a multiply; sampled on rising clk edges.
REQ-005 X  input  WIDTH  multiplicand; sampled only on the accepting edge.
REQ-006 Y  input  WIDTH  multiplier; sampled only on the accepting edge.
REQ-007 valid  output  1  one-cycle pulse; product is final in this cycle.
REQ-008 busy  output  1  high while an operation is in progress.
REQ-009 product  output  2*WIDTH  result register; product[2*WIDTH-1:WIDTH] is the high half, product[WIDTH-1:0] is the low half.

Function
REQ-010 FSM states: IDLE and RUN; the encoding is defined in the package.
REQ-011 In IDLE with start=1 at an edge, the block shall accept the request: M<=X; P<={WIDTH zeros, Y}; count<=0; state<=RUN.
REQ-012 In IDLE with start=0, the FSM and the P and M registers shall hold.
REQ-013 Each RUN cycle (unsigned build): if P[0]=1, form {carry, sum} = P[2W-1:W] + M as a WIDTH+1-bit result, otherwise use {0, P[2W-1:W]}; then P <= {carry, sum, P[W-1:1]}.
REQ-014 RUN shall last exactly WIDTH cycles; count shall increment each cycle and shall be ceil(log2(WIDTH)) bits wide.
REQ-015 On the edge that completes iteration WIDTH-1, state<=IDLE and valid<=1; valid shall deassert on the next edge.
REQ-016 Latency: start accepted at edge N -> valid high for the one cycle following edge N+WIDTH (edge N+4 for WIDTH=4).
REQ-017 product shall be driven from P at all times.
REQ-018 product shall hold its final value until the next accepted start.
REQ-019 busy=1 exactly while state=RUN.
REQ-020 start asserted while busy=1 shall be ignored and shall not queue.
REQ-021 start asserted in the cycle where valid=1 shall be accepted, because the state is already IDLE.
REQ-022 Every result shall be exact for all operand values; the maximum is (2^W-1)^2, which fits in 2*WIDTH bits, so no overflow is possible.

Reset
REQ-023 rst=0 shall asynchronously force: state=IDLE, P=0, M=0, count=0, valid=0, busy=0, product=0.
REQ-024 Reset mid-RUN shall abort the operation; no valid shall be produced; the first start after rst deasserts shall be accepted normally.

Configuration
REQ-025 Macro MULT_SIGNED_EN defined: X and Y shall be two's complement.
REQ-026 With MULT_SIGNED_EN, iterations 0..WIDTH-2 shall add M sign-extended, and the right shift shall replicate the sum's sign bit (arithmetic shift).
REQ-027 With MULT_SIGNED_EN, the final iteration shall subtract M when P[0]=1.
REQ-028 With MULT_SIGNED_EN, product shall be the two's-complement 2*WIDTH-bit result; -2^(W-1) * -2^(W-1) shall be exact.
REQ-029 MULT_SIGNED_EN undefined: unsigned behaviour per REQ-013; ports and latency shall be identical in both builds.

Structure
REQ-030 Package mult_pkg shall hold the FSM state typedef (IDLE, RUN), the default-width constant, and the count-width function.
REQ-031 One sub-module, mult_add_stage, shall be combinational: inputs upper half, M, P[0], and a last-iteration flag; output the next upper half plus the shift-in bit.
REQ-032 Sequencing, handshake and registers shall live in the top module.

Verification
REQ-033 Unsigned, WIDTH=4: X=13, Y=11, start pulse -> busy high for 4 cycles, then valid pulse with product=8'h8F.
REQ-034 Unsigned: X=15, Y=15 -> product=8'hE1; X=0, Y=9 -> product=8'h00; product holds afterwards until the next start.
REQ-035 Start held high for 10 cycles with X=3, Y=5 -> first result 8'h0F after 4 busy cycles; start in the valid cycle begins a second operation, with no gap in busy beyond that cycle.
REQ-036 Start during busy with different X/Y -> ignored; the in-flight result is unchanged.
REQ-037 rst pulled low after the 2nd RUN cycle -> all outputs 0 immediately; no valid; a following X=2, Y=7 run gives 8'h0E.
REQ-038 MULT_SIGNED_EN: X=-3, Y=5 -> 8'hF1; X=-8, Y=-8 -> 8'h40; X=7, Y=-1 -> 8'hF9.
